// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: sequences the fuzzy irrigation datapath.
// A sample starts when the IDLE interval expires or on a manual request.
// The scheduler strobes sensor_latch, waits SETTLE_CYCLES for the
// combinational result, then waters for irrigation_time units and cools down.
//
// Ports:
//   clk, reset           : single clock, synchronous active-high reset
//   enable               : scheduler enable (low outside IDLE aborts the cycle)
//   manual_req           : level request for an immediate sample (IDLE only)
//   irrigation_time[7:0] : defuzzified watering duration in units
//   rain_present         : rain flag from the datapath
//   sensor_latch         : one-cycle capture strobe (first SETTLE cycle)
//   valve_on             : pump valve drive
//   busy                 : high in any state other than IDLE
//   remaining[7:0]       : units left in WATER, 0 elsewhere
//   state[1:0]           : IDLE=0, SETTLE=1, WATER=2, COOLDOWN=3
//   cycle_done           : one-cycle pulse on return to IDLE
//   skipped, aborted     : outcome flags, valid with cycle_done
//
// Optional feature macro: IRRIG_RAIN_ABORT_EN -- rain during WATER cuts
// watering short and goes straight to COOLDOWN.
module irrigation_scheduler #(
   parameter int unsigned TICKS_PER_UNIT  = 50_000_000,
   parameter int unsigned SAMPLE_INTERVAL = 60,
   parameter int unsigned SETTLE_CYCLES   = 4,
   parameter int unsigned COOLDOWN_UNITS  = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       manual_req,
   input  logic [7:0] irrigation_time,
   input  logic       rain_present,
   output logic       sensor_latch,
   output logic       valve_on,
   output logic       busy,
   output logic [7:0] remaining,
   output logic [1:0] state,
   output logic       cycle_done,
   output logic       skipped,
   output logic       aborted
);

   localparam int unsigned PRE_W = $clog2(TICKS_PER_UNIT);
   localparam int unsigned INT_W = $clog2(SAMPLE_INTERVAL + 1);
   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned CD_W  = $clog2(COOLDOWN_UNITS + 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_WATER    = 2'd2,
      ST_COOLDOWN = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [INT_W-1:0] intv_q, intv_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [CD_W-1:0]  cool_q, cool_d;
   logic [7:0]       remaining_q, remaining_d;
   logic             abort_flag_q, abort_flag_d;
   logic             sensor_latch_q, sensor_latch_d;
   logic             valve_on_q, valve_on_d;
   logic             busy_q, busy_d;
   logic             cycle_done_q, cycle_done_d;
   logic             skipped_q, skipped_d;
   logic             aborted_q, aborted_d;
   logic             unit_tick_c;
   logic             rain_abort_c;

   assign unit_tick_c = (presc_q == PRE_W'(TICKS_PER_UNIT - 1));

`ifdef IRRIG_RAIN_ABORT_EN
   assign rain_abort_c = rain_present;
`else
   assign rain_abort_c = 1'b0;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d        = state_q;
      presc_d        = unit_tick_c ? '0 : presc_q + PRE_W'(1);
      intv_d         = intv_q;
      settle_d       = settle_q;
      cool_d         = cool_q;
      remaining_d    = remaining_q;
      abort_flag_d   = abort_flag_q;
      sensor_latch_d = 1'b0;
      cycle_done_d   = 1'b0;
      skipped_d      = 1'b0;
      aborted_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable && unit_tick_c) intv_d = intv_q + INT_W'(1);
            // Manual request and interval expiry merge into one transition
            if (enable && (manual_req ||
                (unit_tick_c && intv_q == INT_W'(SAMPLE_INTERVAL - 1)))) begin
               state_d        = ST_SETTLE;
               intv_d         = '0;
               settle_d       = '0;
               abort_flag_d   = 1'b0;
               sensor_latch_d = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
               settle_d = '0;
               if (irrigation_time == 8'd0 || rain_present) begin
                  state_d      = ST_IDLE;
                  cycle_done_d = 1'b1;
                  skipped_d    = 1'b1;
               end else begin
                  state_d     = ST_WATER;
                  remaining_d = irrigation_time;
               end
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         ST_WATER: begin
            if (rain_abort_c) begin
               state_d      = ST_COOLDOWN;
               cool_d       = '0;
               abort_flag_d = 1'b1;
            end else if (unit_tick_c) begin
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) begin
                  state_d = ST_COOLDOWN;
                  cool_d  = '0;
               end
            end
         end
         ST_COOLDOWN: begin
            if (unit_tick_c) begin
               if (cool_q == CD_W'(COOLDOWN_UNITS - 1)) begin
                  state_d      = ST_IDLE;
                  cool_d       = '0;
                  cycle_done_d = 1'b1;
                  aborted_d    = abort_flag_q;
               end else begin
                  cool_d = cool_q + CD_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Disable outside IDLE abandons the cycle as a skip
      if (state_q != ST_IDLE && !enable) begin
         state_d        = ST_IDLE;
         intv_d         = '0;
         settle_d       = '0;
         cool_d         = '0;
         abort_flag_d   = 1'b0;
         sensor_latch_d = 1'b0;
         cycle_done_d   = 1'b1;
         skipped_d      = 1'b1;
         aborted_d      = 1'b0;
      end

      // First unit after any state entry is full length
      if (state_d != state_q) presc_d = '0;
      if (state_d != ST_WATER) remaining_d = 8'd0;
      valve_on_d = (state_d == ST_WATER);
      busy_d     = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         presc_q        <= '0;
         intv_q         <= '0;
         settle_q       <= '0;
         cool_q         <= '0;
         remaining_q    <= 8'd0;
         abort_flag_q   <= 1'b0;
         sensor_latch_q <= 1'b0;
         valve_on_q     <= 1'b0;
         busy_q         <= 1'b0;
         cycle_done_q   <= 1'b0;
         skipped_q      <= 1'b0;
         aborted_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         presc_q        <= presc_d;
         intv_q         <= intv_d;
         settle_q       <= settle_d;
         cool_q         <= cool_d;
         remaining_q    <= remaining_d;
         abort_flag_q   <= abort_flag_d;
         sensor_latch_q <= sensor_latch_d;
         valve_on_q     <= valve_on_d;
         busy_q         <= busy_d;
         cycle_done_q   <= cycle_done_d;
         skipped_q      <= skipped_d;
         aborted_q      <= aborted_d;
      end
   end

   assign state        = state_q;
   assign sensor_latch = sensor_latch_q;
   assign valve_on     = valve_on_q;
   assign busy         = busy_q;
   assign remaining    = remaining_q;
   assign cycle_done   = cycle_done_q;
   assign skipped      = skipped_q;
   assign aborted      = aborted_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler: randomized bench for irrigation_scheduler with a
// phase/elapsed-time reference model (durations as unit*tick arithmetic).
module tb_irrigation_scheduler;

   localparam int TPU = 4;
   localparam int SI  = 3;
   localparam int SET = 2;
   localparam int CD  = 2;
`ifdef IRRIG_RAIN_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, enable, manual_req, rain_present;
   logic [7:0] irrigation_time;
   logic       sensor_latch, valve_on, busy, cycle_done, skipped, aborted;
   logic [7:0] remaining;
   logic [1:0] state;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: phase, cycles elapsed in phase, outcome flags
   int m_phase, m_t, m_intv, m_dur;
   bit m_abort;
   bit e_latch, e_done, e_skip, e_abort;

   irrigation_scheduler #(
      .TICKS_PER_UNIT (TPU),
      .SAMPLE_INTERVAL(SI),
      .SETTLE_CYCLES  (SET),
      .COOLDOWN_UNITS (CD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .manual_req     (manual_req),
      .irrigation_time(irrigation_time),
      .rain_present   (rain_present),
      .sensor_latch   (sensor_latch),
      .valve_on       (valve_on),
      .busy           (busy),
      .remaining      (remaining),
      .state          (state),
      .cycle_done     (cycle_done),
      .skipped        (skipped),
      .aborted        (aborted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge
   task automatic model_step();
      int nxt;
      e_latch = 0; e_done = 0; e_skip = 0; e_abort = 0;
      if (reset) begin
         m_phase = 0; m_t = 0; m_intv = 0; m_abort = 0;
         return;
      end
      nxt = m_phase;
      case (m_phase)
         0: begin
            bit tick;
            tick = (m_t % TPU) == TPU - 1;
            if (enable && (manual_req || (tick && m_intv + 1 == SI))) begin
               nxt = 1; m_intv = 0; e_latch = 1;
            end else if (enable && tick) begin
               m_intv++;
            end
         end
         1: if (m_t == SET - 1) begin
            if (irrigation_time == 0 || rain_present) begin
               nxt = 0; e_done = 1; e_skip = 1;
            end else begin
               nxt = 2; m_dur = int'(irrigation_time); m_abort = 0;
            end
         end
         2: if (ABORT_EN && rain_present) begin
            nxt = 3; m_abort = 1;
         end else if (m_t == m_dur * TPU - 1) begin
            nxt = 3;
         end
         default: if (m_t == CD * TPU - 1) begin
            nxt = 0; e_done = 1; e_abort = m_abort;
         end
      endcase
      if (m_phase != 0 && !enable) begin
         nxt = 0; e_done = 1; e_skip = 1; e_abort = 0; e_latch = 0; m_intv = 0;
      end
      if (nxt != m_phase) m_t = 0;
      else m_t++;
      m_phase = nxt;
   endtask

   task automatic compare_all();
      int exp_rem;
      exp_rem = (m_phase == 2) ? m_dur - m_t / TPU : 0;
      chk("state",        32'(state),        32'(m_phase));
      chk("valve_on",     32'(valve_on),     32'(m_phase == 2));
      chk("busy",         32'(busy),         32'(m_phase != 0));
      chk("remaining",    32'(remaining),    32'(exp_rem));
      chk("sensor_latch", 32'(sensor_latch), 32'(e_latch));
      chk("cycle_done",   32'(cycle_done),   32'(e_done));
      chk("skipped",      32'(skipped),      32'(e_skip));
      chk("aborted",      32'(aborted),      32'(e_abort));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      int valve_cnt, latch_cnt;
      int p_man, p_rain, p_dis, p_rst;

      reset = 1'b1; enable = 1'b0; manual_req = 1'b0;
      rain_present = 1'b0; irrigation_time = 8'd0;
      m_phase = 0; m_t = 0; m_intv = 0; m_dur = 0; m_abort = 0;
      repeat (3) cycle();
      chk("reset_state", 32'({state, valve_on, busy, remaining, cycle_done}), 32'd0);

      // Automatic interval with zero duration: skipped samples only
      reset = 1'b0; enable = 1'b1;
      repeat (40) cycle();

      // Nominal manual cycle, itime=10
      while (m_phase != 0 || dut.state != 2'd0) cycle();
      manual_req = 1'b1; irrigation_time = 8'd10;
      valve_cnt = 0; latch_cnt = 0;
      for (int i = 0; i < 55; i++) begin
         cycle();
         manual_req = 1'b0;
         valve_cnt += int'(valve_on);
         latch_cnt += int'(sensor_latch);
      end
      chk("nominal_water_cycles", 32'(valve_cnt), 32'd40);
      chk("nominal_latch_pulses", 32'(latch_cnt), 32'd1);

      // Randomized episodes: plain, rain, disable, reset-heavy
      for (int ep = 0; ep < 32; ep++) begin
         p_man  = 5;
         p_rain = (ep % 4 == 1 || ep % 4 == 3) ? 3 : 0;
         p_dis  = (ep % 4 == 2 || ep % 4 == 3) ? 2 : 0;
         p_rst  = (ep % 4 == 3) ? 10 : 0;
         for (int c = 0; c < 250; c++) begin
            manual_req   = ($urandom_range(0, 99) < p_man);
            rain_present = ($urandom_range(0, 99) < p_rain);
            enable       = ($urandom_range(0, 99) >= p_dis);
            reset        = ($urandom_range(0, 999) < p_rst);
            if ($urandom_range(0, 9) == 0) irrigation_time = 8'($urandom_range(0, 12));
            cycle();
         end
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
